// File: rtl/spad_fifo_ctrl_if.sv
// Producer, consumer, scratchpad and status signals of spad_fifo_ctrl.
// The slave modport is the controller's view; master is the surrounding logic.
interface spad_fifo_ctrl_if #(
   parameter int unsigned SPAD_ADDR_BITS = 4,
   parameter int unsigned DATA_W         = 128
);
   logic                      in_flush;
   logic                      in_wr_valid;
   logic [DATA_W-1:0]         in_wr_data;
   logic                      out_wr_ready;
   logic                      out_rd_valid;
   logic [DATA_W-1:0]         out_rd_data;
   logic                      in_rd_ready;
   logic [SPAD_ADDR_BITS-1:0] out_spad_raddr;
   logic [SPAD_ADDR_BITS-1:0] out_spad_waddr;
   logic [DATA_W-1:0]         out_spad_wdata;
   logic                      out_spad_we;
   logic [DATA_W-1:0]         in_spad_rdata;
   logic [SPAD_ADDR_BITS:0]   out_count;
   logic                      out_full;
   logic                      out_empty;
   logic                      out_afull;

   modport slave (
      input  in_flush, in_wr_valid, in_wr_data, in_rd_ready, in_spad_rdata,
      output out_wr_ready, out_rd_valid, out_rd_data, out_spad_raddr,
             out_spad_waddr, out_spad_wdata, out_spad_we, out_count,
             out_full, out_empty, out_afull
   );

   modport master (
      output in_flush, in_wr_valid, in_wr_data, in_rd_ready, in_spad_rdata,
      input  out_wr_ready, out_rd_valid, out_rd_data, out_spad_raddr,
             out_spad_waddr, out_spad_wdata, out_spad_we, out_count,
             out_full, out_empty, out_afull
   );
endinterface

// File: rtl/spad_fifo_ctrl.sv
// Runs the 16x128 scratchpad as a circular FIFO between the fill engine and
// the detection datapath, with a registered read-data output stage.
module spad_fifo_ctrl #(
   parameter int unsigned SPAD_ADDR_BITS = 4,
   parameter int unsigned SPAD_SIZE      = 16,
   parameter int unsigned DATA_W         = 128,
   parameter int unsigned AFULL_THRESH   = 12
) (
   input logic             in_clk,
   input logic             in_rst_n,
   spad_fifo_ctrl_if.slave bus
);
   typedef logic [SPAD_ADDR_BITS:0] cnt_t;
   localparam cnt_t SIZE_C  = cnt_t'(SPAD_SIZE);
   localparam cnt_t AFULL_C = cnt_t'(AFULL_THRESH);

   logic [SPAD_ADDR_BITS-1:0] wptr;
   logic [SPAD_ADDR_BITS-1:0] rptr;
   cnt_t                      count;
   logic                      rd_valid;
   logic [DATA_W-1:0]         rd_data;
   logic                      full;
   logic                      empty;
   logic                      afull;
   logic                      wr_ready;
   logic                      push;
   logic                      load;

   always_comb begin
      full     = (count == SIZE_C);
      empty    = (count == '0);
      afull    = (count >= AFULL_C);
      wr_ready = !full && !bus.in_flush;
      // Write enable is held low while reset is asserted, even with a valid producer.
      push     = bus.in_wr_valid && wr_ready && in_rst_n;
      load     = !empty && (!rd_valid || bus.in_rd_ready) && !bus.in_flush;
   end

   always_ff @(posedge in_clk or negedge in_rst_n) begin
      if (!in_rst_n) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
      end else if (bus.in_flush) begin
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         rd_valid <= 1'b0;
      end else begin
         if (push) begin
            wptr <= wptr + 1'b1;
         end
         if (load) begin
            rptr     <= rptr + 1'b1;
            rd_data  <= bus.in_spad_rdata;
            rd_valid <= 1'b1;
         end else if (bus.in_rd_ready) begin
            rd_valid <= 1'b0;
         end
         case ({push, load})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign bus.out_wr_ready   = wr_ready;
   assign bus.out_rd_valid   = rd_valid;
   assign bus.out_rd_data    = rd_data;
   assign bus.out_spad_raddr = rptr;
   assign bus.out_spad_waddr = wptr;
   assign bus.out_spad_wdata = bus.in_wr_data;
   assign bus.out_spad_we    = push;
   assign bus.out_count      = count;
   assign bus.out_full       = full;
   assign bus.out_empty      = empty;
   assign bus.out_afull      = afull;
endmodule
